// File: rtl/mont_exp_requester.sv
// mont_exp_requester: left-to-right square-and-multiply sequencer driving one Montgomery multiplier
module mont_exp_requester #(
  parameter int E_WIDTH = 512,
  parameter int LEN_W = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [511:0]       in_x,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [LEN_W-1:0]   in_e_len,
  input  logic [511:0]       in_m,
  input  logic [511:0]       in_r,
  input  logic [511:0]       in_r2,
  output logic [511:0]       result,
  output logic               done,
  output logic               busy,
  output logic               mont_start,
  output logic [513:0]       mont_a,
  output logic [513:0]       mont_b,
  output logic [513:0]       mont_m,
  input  logic [511:0]       mont_result,
  input  logic               mont_done
);
  localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
  typedef enum logic [3:0] {
    IDLE, CALC_XT, WAIT_XT, LOOP, SQR, WAIT_SQR, MULT, WAIT_MULT, CONV, WAIT_CONV, DONE
  } state_t;
  state_t state_q, state_d;
  logic [E_WIDTH-1:0] e_q, e_d;
  logic [LEN_W-1:0] i_q, i_d;
  logic [511:0] r_q, r_d, xt_q, xt_d, acc_q, acc_d, result_q, result_d;
  logic [513:0] a_q, a_d, b_q, b_d, m_q, m_d;
  logic done_q, busy_q, ms_q;
  // The x*r2 operands come straight from the inputs on the accepting edge, so
  // the first multiply issues in the very next cycle without extra latches.
  always_comb begin
    state_d = state_q;
    e_d = e_q;
    i_d = i_q;
    r_d = r_q;
    xt_d = xt_q;
    acc_d = acc_q;
    result_d = result_q;
    a_d = a_q;
    b_d = b_q;
    m_d = m_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CALC_XT;
        e_d = in_e;
        r_d = in_r;
        i_d = (in_e_len > LEN_W'(E_WIDTH)) ? LEN_W'(E_WIDTH) : in_e_len;
        a_d = {2'b0, in_x};
        b_d = {2'b0, in_r2};
        m_d = {2'b0, in_m};
      end
      CALC_XT: state_d = WAIT_XT;
      WAIT_XT: if (mont_done) begin
        xt_d = mont_result;
        acc_d = r_q;
        state_d = LOOP;
      end
      LOOP: begin
        state_d = (i_q == '0) ? CONV : SQR;
        i_d = (i_q == '0) ? i_q : i_q - 1'b1;
        a_d = {2'b0, acc_q};
        b_d = (i_q == '0) ? 514'd1 : {2'b0, acc_q};
      end
      SQR: state_d = WAIT_SQR;
      WAIT_SQR: if (mont_done) begin
        acc_d = mont_result;
        state_d = e_q[i_q[IW-1:0]] ? MULT : LOOP;
        a_d = {2'b0, mont_result};
        b_d = {2'b0, xt_q};
      end
      MULT: state_d = WAIT_MULT;
      WAIT_MULT: if (mont_done) begin
        acc_d = mont_result;
        state_d = LOOP;
      end
      CONV: state_d = WAIT_CONV;
      WAIT_CONV: if (mont_done) begin
        result_d = mont_result;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      e_q <= '0;
      i_q <= '0;
      r_q <= '0;
      xt_q <= '0;
      acc_q <= '0;
      result_q <= '0;
      a_q <= '0;
      b_q <= '0;
      m_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      ms_q <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q <= e_d;
      i_q <= i_d;
      r_q <= r_d;
      xt_q <= xt_d;
      acc_q <= acc_d;
      result_q <= result_d;
      a_q <= a_d;
      b_q <= b_d;
      m_q <= m_d;
      done_q <= state_d == DONE;
      busy_q <= state_d != IDLE;
      ms_q <= state_d inside {CALC_XT, SQR, MULT, CONV};
    end
  end
  assign result = result_q;
  assign done = done_q;
  assign busy = busy_q;
  assign mont_start = ms_q;
  assign mont_a = a_q;
  assign mont_b = b_q;
  assign mont_m = m_q;
endmodule

// File: tb/tb_mont_exp_requester.sv
// tb_mont_exp_requester: randomized exponentiations against a plain modexp model and a Montgomery multiplier model
module tb_mont_exp_requester;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [511:0] in_x = '0, in_e = '0, in_m = '0, in_r = '0, in_r2 = '0, mont_result = '0;
  logic [9:0] in_e_len = '0;
  logic [511:0] result;
  logic done, busy, mont_start, mont_done = 1'b0;
  logic [513:0] mont_a, mont_b, mont_m;
  int checks = 0, errors = 0;
  int lat = 20;
  bit spur = 0, pend = 0;
  int pcnt = 0;
  logic [513:0] cap_a = '0, cap_b = '0, cap_m = '0;
  bit run_active = 0;
  logic [511:0] exp_result = '0, cur_m = '0;
  int exp_cnt = 0, base = 0, mtot = 0, last_cnt = 0, since = 0;
  bit waiting = 0;

  mont_exp_requester #(.E_WIDTH(512), .LEN_W(10)) dut (
    .clk(clk), .resetn(resetn), .start(start), .in_x(in_x), .in_e(in_e), .in_e_len(in_e_len),
    .in_m(in_m), .in_r(in_r), .in_r2(in_r2), .result(result), .done(done), .busy(busy),
    .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
    .mont_result(mont_result), .mont_done(mont_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [513:0] act, input logic [513:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mmul(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m);
    logic [513:0] t;
    t = '0;
    for (int k = 0; k < 512; k++) begin
      if (a[k]) t = t + {2'b0, b};
      if (t[0]) t = t + {2'b0, m};
      t = t >> 1;
    end
    if (t >= {2'b0, m}) t = t - {2'b0, m};
    return t[511:0];
  endfunction

  function automatic logic [511:0] modexp(input logic [511:0] x, input logic [511:0] e, input int len, input logic [511:0] m);
    logic [1023:0] acc, mm, xx;
    acc = 1024'd1;
    mm = {512'b0, m};
    xx = {512'b0, x};
    for (int k = len - 1; k >= 0; k--) begin
      acc = (acc * acc) % mm;
      if (e[k[8:0]]) acc = (acc * xx) % mm;
    end
    acc = acc % mm;
    return acc[511:0];
  endfunction

  function automatic logic [511:0] rmod(input logic [511:0] m);
    logic [1023:0] big;
    big = '0;
    big[512] = 1'b1;
    big = big % {512'b0, m};
    return big[511:0];
  endfunction

  function automatic logic [511:0] r2mod(input logic [511:0] m);
    logic [1023:0] r;
    r = {512'b0, rmod(m)};
    r = (r * r) % {512'b0, m};
    return r[511:0];
  endfunction

  function automatic int mcount(input logic [511:0] e, input int len);
    int n;
    n = 2 + len;
    for (int k = 0; k < len; k++) n += int'(e[k[8:0]]);
    return n;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [511:0] rnd_mod(input bit wide);
    logic [511:0] m;
    m = rnd512();
    if (!wide) m = {448'b0, m[63:0]};
    m[0] = 1'b1;
    if (wide) m[511] = 1'b1;
    else m[63] = 1'b1;
    return m;
  endfunction

  // multiplier model: captures operands on mont_start, answers after lat cycles
  initial forever begin
    @(posedge clk);
    #1;
    mont_done = 1'b0;
    if (spur) begin
      spur = 0;
      mont_done = 1'b1;
      mont_result = rnd512();
    end else if (pend) begin
      pcnt--;
      if (pcnt == 0) begin
        pend = 0;
        mont_done = 1'b1;
        mont_result = mmul(cap_a[511:0], cap_b[511:0], cap_m[511:0]);
      end
    end else if (mont_start) begin
      pend = 1;
      pcnt = lat;
      cap_a = mont_a;
      cap_b = mont_b;
      cap_m = mont_m;
    end
  end

  // compare process
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      chk("rst_result", result, '0);
      chk("rst_flags", {done, busy, mont_start}, '0);
      chk("rst_ops", mont_a | mont_b | mont_m, '0);
      waiting = 0;
    end else begin
      if (waiting) since++;
      if (mont_done && run_active && busy) begin
        waiting = 1;
        since = 0;
      end
      if (mont_start) begin
        mtot++;
        chk("mstart_in_run", run_active, 1);
        if (waiting) chk("mstart_gap_le2", since <= 2, 1);
        waiting = 0;
      end
      chk("busy", busy, run_active);
      if (run_active) chk("mont_m", mont_m, {2'b0, cur_m});
      if (run_active && pend) begin
        chk("op_a_stable", mont_a, cap_a);
        chk("op_b_stable", mont_b, cap_b);
      end
      if (done) begin
        chk("done_in_run", run_active, 1);
        chk("result", result, exp_result);
        last_cnt = mtot - base;
        chk("mult_count", last_cnt, exp_cnt);
        waiting = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [511:0] x, input logic [511:0] e, input int len, input logic [511:0] m);
    int lc;
    lc = (len > 512) ? 512 : len;
    in_x = x;
    in_e = e;
    in_e_len = len[9:0];
    in_m = m;
    in_r = rmod(m);
    in_r2 = r2mod(m);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_result = modexp(x, e, lc, m);
    exp_cnt = mcount(e, lc);
    cur_m = m;
    base = mtot;
    run_active = 1;
    in_x = rnd512();
    in_e = rnd512();
    in_m = rnd512();
    in_r = rnd512();
    in_r2 = rnd512();
    in_e_len = 10'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    chk("done_seen", done, 1);
    #1;
    run_active = 0;
  endtask

  initial begin
    logic [511:0] m, x, e;
    int n, len;
    chk("pin_modexp", modexp(512'd3, 512'd5, 3, 512'd7), 514'd5);
    chk("pin_rmod", rmod(512'd7), 514'd4);
    chk("pin_r2mod", r2mod(512'd7), 514'd2);
    chk("pin_mmul", mmul(512'd3, 512'd2, 512'd7), 514'd5);
    chk("pin_mcount", mcount(512'h8001, 16), 514'd20);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    idle(2);
    lat = 20;
    launch(512'd3, 512'd5, 3, 512'd7);
    wait_done(2000);
    chk("t1_result", result, 514'd5);
    chk("t1_count", last_cnt, 514'd7);
    idle(3);
    chk("t1_result_held", result, 514'd5);
    launch(512'd3, 512'd5, 0, 512'd7);
    wait_done(2000);
    chk("t2_result", result, 514'd1);
    chk("t2_count", last_cnt, 514'd2);
    idle(2);
    lat = 4;
    m = rnd_mod(1);
    x = rnd512() % m;
    launch(x, 512'h8001, 16, m);
    wait_done(2000);
    chk("t3_count", last_cnt, 514'd20);
    idle(2);
    lat = 10;
    launch(512'd3, 512'd5, 3, 512'd7);
    repeat (30) @(posedge clk);
    #1;
    in_x = 512'd6;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("t4_busy_kept", busy, 1);
    wait_done(2000);
    chk("t4_result", result, 514'd5);
    idle(2);
    lat = 20;
    launch(512'd12345, 512'hA5, 8, 512'd1000003);
    n = 0;
    while (mtot - base < 2 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("t5_reached_sqr", mtot - base >= 2, 1);
    repeat (3) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("t5_rst_result", result, '0);
    chk("t5_rst_flags", {done, busy, mont_start}, '0);
    chk("t5_rst_ops", mont_a | mont_b | mont_m, '0);
    run_active = 0;
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;
    n = 0;
    while (pend && n < 100) begin
      @(posedge clk);
      n++;
    end
    idle(3);
    chk("t5_idle_after_late", {busy, done}, '0);
    lat = 3;
    launch(512'd12345, 512'hA5, 8, 512'd1000003);
    wait_done(2000);
    idle(2);
    spur = 1;
    idle(3);
    chk("t6_spurious_ignored", {busy, done, mont_start}, '0);
    lat = 1;
    m = rnd_mod(0);
    x = rnd512() % m;
    launch(x, rnd512(), 24, m);
    wait_done(2000);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("start_in_done_ignored", {busy, mont_start}, '0);
    idle(2);
    m = rnd_mod(0);
    x = rnd512() % m;
    e = rnd512();
    launch(x, e, 700, m);
    wait_done(20000);
    chk("clamp_count", last_cnt, mcount(e, 512));
    idle(2);
    for (int t = 0; t < 8; t++) begin
      lat = $urandom_range(1, 6);
      m = rnd_mod(t[0]);
      x = rnd512() % m;
      len = $urandom_range(0, 40);
      launch(x, rnd512(), len, m);
      wait_done((2 + 2 * len) * (lat + 3) + 50);
      idle(1 + $urandom_range(0, 2));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mont_exp_requester.md
Name: mont_exp_requester

Overview:
- Initiator/sequencer for the Montgomery multiplier's start/done interface; computes result = x^e mod M by left-to-right square-and-multiply.
- Issues single multiplications on the mont_* ports and consumes each product.
- Sits between the top-level RSA control and one montgomery instance; it owns the requesting end of the protocol.

Parameters:
E_WIDTH, 512, exponent register width in bits
LEN_W, 10, width of exponent-length input; must satisfy 2^LEN_W > E_WIDTH

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  one-cycle request pulse; samples all in_* operands
in_x  input  512  base, < M
in_e  input  E_WIDTH  exponent
in_e_len  input  LEN_W  number of exponent bits to scan, 0..E_WIDTH
in_m  input  512  odd modulus
in_r  input  512  R mod M, R = 2^512
in_r2  input  512  R^2 mod M
result  output  512  x^e mod M, held until the next accepted start
done  output  1  one-cycle pulse when result is valid
busy  output  1  high from the cycle after an accepted start through the done cycle
mont_start  output  1  one-cycle pulse to the multiplier
mont_a  output  514  operand A, upper 2 bits zero
mont_b  output  514  operand B, upper 2 bits zero
mont_m  output  514  modulus, upper 2 bits zero
mont_result  input  512  product A*B*R^-1 mod M
mont_done  input  1  one-cycle product-valid pulse

Behaviour:
- Reset (asynchronous, resetn=0): state IDLE; result=0, done=0, busy=0, mont_start=0, mont_a/b/m=0; internal registers cleared.
- start in IDLE: latch x, e, e_len, m, r, r2 into internal registers. Later input changes have no effect.
- start while busy: ignored.
- States:
  - IDLE
  - CALC_XT: issue x*r2, giving xt = x in Montgomery form.
  - WAIT_XT: on mont_done, xt := mont_result; acc := r; i := e_len.
  - LOOP: if i==0, go to CONV. Otherwise i := i-1 and go to SQR.
  - SQR / WAIT_SQR: issue acc*acc. On mont_done, acc := mont_result. Then go to MULT if e[i]=1, else to LOOP.
  - MULT / WAIT_MULT: issue acc*xt. On mont_done, acc := mont_result, then go to LOOP.
  - CONV / WAIT_CONV: issue acc*1. On mont_done, result := mont_result, go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Issue states: mont_start=1 for exactly one cycle. mont_a, mont_b and mont_m are driven registered and stay stable from the mont_start cycle until mont_done is sampled. mont_m always equals the latched m.
- Timing:
  - First mont_start is in the cycle after start is sampled.
  - Each following mont_start is at most 2 cycles after the previous mont_done.
  - Number of multiplications = 2 + e_len + popcount(e[e_len-1:0]).
- Widths: operands are zero-extended from 512 to 514 bits; mont_result is taken as is (no reduction in this block).
- Boundaries:
  - e_len=0: no SQR/MULT; result = r*1*R^-1 = 1 mod M (needs M>1).
  - e_len > E_WIDTH: clamp to E_WIDTH.
  - e=0 with e_len>0: squarings only; result 1.
  - mont_done outside WAIT_* states: ignored.
  - mont_done in the same cycle as mont_start: not allowed by the multiplier protocol; no requirement.
- Reset mid-operation: immediate return to IDLE with outputs at their reset values. A mont_done arriving after reset is ignored.
- start in the DONE cycle: ignored; busy is still high.

Test Plan:
- Tiny modulus: M=7, x=3, e=5, e_len=3, r=4, r2=2, with a behavioural montgomery model of 20-cycle latency → result=5, done one pulse, exactly 7 mont_start pulses, operands stable during each multiply.
- e_len=0, same operands → result=1, exactly 2 mont_start pulses, done asserted.
- e=0x8001, e_len=16, 512-bit M/x from the Python vector generator → result matches Python pow(x,e,M), 16 squarings + 2 multiplies + 2 conversions.
- start re-pulsed mid-run with different in_x → ignored, result unchanged from the first request, busy stays high.
- resetn low during WAIT_SQR → all outputs 0 at once. Late mont_done after release is ignored. A fresh start computes correctly.
- Model drives a spurious mont_done while IDLE and a zero-latency-plus-1 multiplier → no state change in IDLE, correct result with minimum gaps.
